// File: rtl/tdp_ram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdp_ram_pkg
//  Description : Shared encodings for the initialising true-dual-port RAM:
//                read-during-write modes, FSM states and a mode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tdp_ram_pkg;

  // Same-port read-during-write behaviour of the q output on a write
  localparam int C_RDW_WRITE_FIRST = 0;  // q shows the data just written
  localparam int C_RDW_READ_FIRST  = 1;  // q shows the word being replaced
  localparam int C_RDW_NO_CHANGE   = 2;  // q keeps its previous value

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // True when a write on a port in this mode produces a fresh q value
  function automatic logic rdw_reports_write(input int mode);
    return (mode != C_RDW_NO_CHANGE);
  endfunction

endpackage : tdp_ram_pkg
`default_nettype wire

// File: rtl/tdp_ram_core.sv
`default_nettype none
// ============================================================================
//  Module      : tdp_ram_core
//  Description : Resetless true-dual-port memory array with per-port
//                read-during-write behaviour and output-load enables.
//                Port A wins when both ports write the same word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_core
  import tdp_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int RDW_A  = C_RDW_WRITE_FIRST,
  parameter int RDW_B  = C_RDW_WRITE_FIRST
) (
  input  logic              clk,
  input  logic              en_a_i,
  input  logic              we_a_i,
  input  logic              oe_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] din_a_i,
  output logic [DATA_W-1:0] dout_a_o,
  input  logic              en_b_i,
  input  logic              we_b_i,
  input  logic              oe_b_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [DATA_W-1:0] din_b_i,
  output logic [DATA_W-1:0] dout_b_o
);

  localparam int C_DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [C_DEPTH];
  logic [DATA_W-1:0] dout_a_q;
  logic [DATA_W-1:0] dout_b_q;

  // Both ports in one process: the later port-A write takes priority on a
  // same-address collision, and every read sees the pre-edge contents.
  always_ff @(posedge clk) begin
    if (en_b_i && we_b_i) mem_q[addr_b_i] <= din_b_i;
    if (en_a_i && we_a_i) mem_q[addr_a_i] <= din_a_i;

    if (en_a_i && oe_a_i) begin
      if (!we_a_i)                           dout_a_q <= mem_q[addr_a_i];
      else if (RDW_A == C_RDW_WRITE_FIRST)   dout_a_q <= din_a_i;
      else if (RDW_A == C_RDW_READ_FIRST)    dout_a_q <= mem_q[addr_a_i];
    end

    if (en_b_i && oe_b_i) begin
      if (!we_b_i)                           dout_b_q <= mem_q[addr_b_i];
      else if (RDW_B == C_RDW_WRITE_FIRST)   dout_b_q <= din_b_i;
      else if (RDW_B == C_RDW_READ_FIRST)    dout_b_q <= mem_q[addr_b_i];
    end
  end

  assign dout_a_o = dout_a_q;
  assign dout_b_o = dout_b_q;

endmodule : tdp_ram_core
`default_nettype wire

// File: rtl/tdp_ram_init.sv
`default_nettype none
// ============================================================================
//  Module      : tdp_ram_init
//  Description : True-dual-port RAM that fills itself with INIT_VAL after
//                reset or on request, with rvalid strobes, optional output
//                register stage and same-address write collision flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_init
  import tdp_ram_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 6,
  parameter int              RDW_A    = 0,
  parameter int              RDW_B    = 0,
  parameter int              OUT_REG  = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              busy,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  output logic              rvalid_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  output logic              rvalid_b,
  output logic              coll
);

  localparam logic C_WR_RPT_A = rdw_reports_write(RDW_A);
  localparam logic C_WR_RPT_B = rdw_reports_write(RDW_B);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   w_cnt_inc;
  logic              w_init, w_ready;
  logic              w_acc_a, w_acc_b, w_upd_a, w_upd_b, w_coll;
  logic              core_en_a, core_we_a;
  logic [ADDR_W-1:0] core_addr_a;
  logic [DATA_W-1:0] core_din_a, dout_a, dout_b;
  logic              rv1_a_q, rv1_b_q, coll1_q;

  // The extra counter bit flags the step past the last address
  assign w_cnt_inc = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
  assign w_init    = (state_q == ST_INIT);
  // A reset edge blocks user accesses so nothing new enters the pipeline
  assign w_ready   = (state_q == ST_READY) && rst_n;
  assign busy      = w_init;

  // Next-state: sweep every address once, then serve ports until re-init
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = w_cnt_inc;
        if (w_cnt_inc[ADDR_W]) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state and init address counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign w_acc_a = w_ready && en_a;
  assign w_acc_b = w_ready && en_b;
  assign w_upd_a = w_acc_a && (!we_a || C_WR_RPT_A);
  assign w_upd_b = w_acc_b && (!we_b || C_WR_RPT_B);
  assign w_coll  = w_acc_a && we_a && w_acc_b && we_b && (addr_a == addr_b);

  // Port A is borrowed by the initialiser while INIT runs
  assign core_en_a   = w_init || w_acc_a;
  assign core_we_a   = w_init || we_a;
  assign core_addr_a = w_init ? cnt_q[ADDR_W-1:0] : addr_a;
  assign core_din_a  = w_init ? INIT_VAL : data_a;

  tdp_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .RDW_A  (RDW_A),
    .RDW_B  (RDW_B)
  ) u_core (
    .clk      (clk),
    .en_a_i   (core_en_a),
    .we_a_i   (core_we_a),
    .oe_a_i   (w_ready),
    .addr_a_i (core_addr_a),
    .din_a_i  (core_din_a),
    .dout_a_o (dout_a),
    .en_b_i   (w_acc_b),
    .we_b_i   (we_b),
    .oe_b_i   (w_ready),
    .addr_b_i (addr_b),
    .din_b_i  (data_b),
    .dout_b_o (dout_b)
  );

  // First pipeline stage: strobes aligned with the RAM output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rv1_a_q <= 1'b0;
      rv1_b_q <= 1'b0;
      coll1_q <= 1'b0;
    end else begin
      rv1_a_q <= w_upd_a;
      rv1_b_q <= w_upd_b;
      coll1_q <= w_coll;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] q2_a_q, q2_b_q;
      logic              rv2_a_q, rv2_b_q, coll2_q;

      // Second stage captures the RAM output only when it carries a new value
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q2_a_q  <= '0;
          q2_b_q  <= '0;
          rv2_a_q <= 1'b0;
          rv2_b_q <= 1'b0;
          coll2_q <= 1'b0;
        end else begin
          if (rv1_a_q) q2_a_q <= dout_a;
          if (rv1_b_q) q2_b_q <= dout_b;
          rv2_a_q <= rv1_a_q;
          rv2_b_q <= rv1_b_q;
          coll2_q <= coll1_q;
        end
      end

      assign q_a      = q2_a_q;
      assign q_b      = q2_b_q;
      assign rvalid_a = rv2_a_q;
      assign rvalid_b = rv2_b_q;
      assign coll     = coll2_q;
    end else begin : g_out_direct
      logic have_a_q, have_b_q;

      // The RAM output cannot be reset, so mask it until it first holds a result
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          have_a_q <= 1'b0;
          have_b_q <= 1'b0;
        end else begin
          have_a_q <= have_a_q || w_upd_a;
          have_b_q <= have_b_q || w_upd_b;
        end
      end

      assign q_a      = have_a_q ? dout_a : '0;
      assign q_b      = have_b_q ? dout_b : '0;
      assign rvalid_a = rv1_a_q;
      assign rvalid_b = rv1_b_q;
      assign coll     = coll1_q;
    end
  endgenerate

endmodule : tdp_ram_init
`default_nettype wire

// File: tb/tb_tdp_ram_init.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdp_ram_init
//  Description : Self-checking bench for tdp_ram_init. Two instances with
//                different modes share the stimulus; a per-instance memory
//                model predicts busy, q, rvalid and coll every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdp_ram_init;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, init_req;
  logic          en_a, we_a, en_b, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;

  logic [1:0]    busy_w, rva_w, rvb_w, coll_w;
  logic [DW-1:0] qa_w [2];
  logic [DW-1:0] qb_w [2];

  int checks = 0;
  int errors = 0;

  // Instance 0: A write-first, B read-first, no output register, INIT 00
  tdp_ram_init #(.DATA_W(DW), .ADDR_W(AW), .RDW_A(0), .RDW_B(1), .OUT_REG(0), .INIT_VAL(8'h00)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_w[0]),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(qa_w[0]), .rvalid_a(rva_w[0]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(qb_w[0]), .rvalid_b(rvb_w[0]),
    .coll(coll_w[0]));

  // Instance 1: A no-change, B write-first, output register, INIT 5A
  tdp_ram_init #(.DATA_W(DW), .ADDR_W(AW), .RDW_A(2), .RDW_B(0), .OUT_REG(1), .INIT_VAL(8'h5A)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy_w[1]),
    .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(qa_w[1]), .rvalid_a(rva_w[1]),
    .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(qb_w[1]), .rvalid_b(rvb_w[1]),
    .coll(coll_w[1]));

  function automatic int cfg_rdwa(input int k); return (k == 0) ? 0 : 2; endfunction
  function automatic int cfg_rdwb(input int k); return (k == 0) ? 1 : 0; endfunction
  function automatic bit cfg_oreg(input int k); return (k == 1); endfunction
  function automatic logic [DW-1:0] cfg_init(input int k); return (k == 0) ? 8'h00 : 8'h5A; endfunction

  // Reference model state
  logic [DW-1:0] mmem [2][DEPTH];
  int            ileft [2];
  logic          s_va [2], s_vb [2], s_c [2];
  logic [DW-1:0] s_da [2], s_db [2];
  logic          e_va [2], e_vb [2], e_c [2], e_busy [2];
  logic [DW-1:0] e_qa [2], e_qb [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic port_res(input int mode, input logic en, input logic we,
                          input logic [DW-1:0] oldv, input logic [DW-1:0] newv,
                          output logic v, output logic [DW-1:0] d);
    v = 1'b0;
    d = '0;
    if (en) begin
      if (!we)            begin v = 1'b1; d = oldv; end
      else if (mode == 0) begin v = 1'b1; d = newv; end
      else if (mode == 1) begin v = 1'b1; d = oldv; end
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic          ra_v, rb_v, c;
      logic [DW-1:0] ra_d, rb_d;
      ra_v = 1'b0; rb_v = 1'b0; c = 1'b0; ra_d = '0; rb_d = '0;
      if (!rst_n) begin
        ileft[k] = DEPTH;
        s_va[k] = 1'b0; s_vb[k] = 1'b0; s_c[k] = 1'b0;
        e_va[k] = 1'b0; e_vb[k] = 1'b0; e_c[k] = 1'b0;
        e_qa[k] = '0;   e_qb[k] = '0;
      end else begin
        if (ileft[k] > 0) begin
          mmem[k][DEPTH - ileft[k]] = cfg_init(k);
          ileft[k]--;
        end else begin
          port_res(cfg_rdwa(k), en_a, we_a, mmem[k][addr_a], data_a, ra_v, ra_d);
          port_res(cfg_rdwb(k), en_b, we_b, mmem[k][addr_b], data_b, rb_v, rb_d);
          c = en_a && we_a && en_b && we_b && (addr_a == addr_b);
          if (en_b && we_b) mmem[k][addr_b] = data_b;
          if (en_a && we_a) mmem[k][addr_a] = data_a;
          if (init_req) ileft[k] = DEPTH;
        end
        if (cfg_oreg(k)) begin
          e_va[k] = s_va[k]; if (s_va[k]) e_qa[k] = s_da[k];
          e_vb[k] = s_vb[k]; if (s_vb[k]) e_qb[k] = s_db[k];
          e_c[k]  = s_c[k];
          s_va[k] = ra_v; s_da[k] = ra_d;
          s_vb[k] = rb_v; s_db[k] = rb_d;
          s_c[k]  = c;
        end else begin
          e_va[k] = ra_v; if (ra_v) e_qa[k] = ra_d;
          e_vb[k] = rb_v; if (rb_v) e_qb[k] = rb_d;
          e_c[k]  = c;
        end
      end
      e_busy[k] = (ileft[k] > 0);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k),     busy_w[k], e_busy[k]);
      chk($sformatf("rvalid_a%0d", k), rva_w[k],  e_va[k]);
      chk($sformatf("rvalid_b%0d", k), rvb_w[k],  e_vb[k]);
      chk($sformatf("q_a%0d", k),      qa_w[k],   e_qa[k]);
      chk($sformatf("q_b%0d", k),      qb_w[k],   e_qb[k]);
      chk($sformatf("coll%0d", k),     coll_w[k], e_c[k]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
  endtask

  task automatic set_in(input logic ea, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic eb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    en_a = ea; we_a = wa; addr_a = aa; data_a = da;
    en_b = eb; we_b = wb; addr_b = ab; data_b = db;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            n;
    logic [AW-1:0] rd_addrs [3];
    rd_addrs[0] = 6'd0; rd_addrs[1] = 6'd31; rd_addrs[2] = 6'd63;

    // Reset: outputs zero, busy high
    rst_n = 1'b0; init_req = 1'b0; idle();
    repeat (3) step();
    chk("rst_busy", busy_w[0], 1'b1);
    chk("rst_q_b",  qb_w[0],   8'h00);

    // Initialisation length after reset release
    rst_n = 1'b1;
    n = 0;
    while (busy_w[0] && n < 200) begin n++; step(); end
    chk("init_len", n, 64);

    // Port B reads after init: 00 one cycle after each request
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, rd_addrs[i], '0);
      step();
      chk("rd_b_rvalid", rvb_w[0], 1'b1);
      chk("rd_b_q",      qb_w[0],  8'h00);
      idle(); step();
      chk("rd_b_pulse",  rvb_w[0], 1'b0);
    end

    // Output register instance: read addr 2 on A appears two edges later
    set_in(1'b1, 1'b0, 6'd2, '0, 1'b0, 1'b0, '0, '0);
    step();
    chk("oreg_n1_rvalid", rva_w[1], 1'b0);
    idle(); step();
    chk("oreg_n2_rvalid", rva_w[1], 1'b1);
    chk("oreg_n2_q",      qa_w[1],  8'h5A);
    step();
    chk("oreg_n3_rvalid", rva_w[1], 1'b0);
    chk("oreg_n3_q_hold", qa_w[1],  8'h5A);

    // Write-first on A, read-first on B over old value 3C at addr 5
    set_in(1'b1, 1'b1, 6'd5, 8'h3C, 1'b0, 1'b0, '0, '0); step();
    set_in(1'b1, 1'b1, 6'd5, 8'hA5, 1'b0, 1'b0, '0, '0); step();
    chk("wf_a_q", qa_w[0], 8'hA5);
    chk("wf_a_rvalid", rva_w[0], 1'b1);
    set_in(1'b1, 1'b1, 6'd5, 8'h3C, 1'b0, 1'b0, '0, '0); step();
    set_in(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 6'd5, 8'hA5); step();
    chk("rf_b_q", qb_w[0], 8'h3C);
    chk("rf_b_rvalid", rvb_w[0], 1'b1);

    // Cross-port: A writes while B reads the same word -> B sees old word
    set_in(1'b1, 1'b1, 6'd5, 8'h77, 1'b1, 1'b0, 6'd5, '0); step();
    chk("xport_old", qb_w[0], 8'hA5);

    // Same-address dual write: coll pulse, port A data stored
    set_in(1'b1, 1'b1, 6'd9, 8'h11, 1'b1, 1'b1, 6'd9, 8'h22); step();
    chk("coll0_on", coll_w[0], 1'b1);
    idle(); step();
    chk("coll0_off", coll_w[0], 1'b0);
    chk("coll1_on",  coll_w[1], 1'b1);
    step();
    chk("coll1_off", coll_w[1], 1'b0);
    set_in(1'b1, 1'b0, 6'd9, '0, 1'b0, 1'b0, '0, '0); step();
    chk("coll0_data", qa_w[0], 8'h11);
    idle(); step();
    chk("coll1_data", qa_w[1], 8'h11);

    // Re-init on request; writes during busy are dropped
    set_in(1'b1, 1'b1, 6'd7, 8'hFF, 1'b0, 1'b0, '0, '0); step();
    idle(); init_req = 1'b1; step();
    init_req = 1'b0;
    n = 0;
    while (busy_w[0] && n < 200) begin
      n++;
      set_in(1'b1, 1'b1, 6'd7, 8'hFF, 1'b1, 1'b1, AW'($urandom_range(0, 63)), DW'($urandom));
      step();
    end
    chk("reinit_len", n, 64);
    idle();
    set_in(1'b1, 1'b0, 6'd7, '0, 1'b0, 1'b0, '0, '0); step();
    chk("reinit_q0", qa_w[0], 8'h00);
    idle(); step();
    chk("reinit_q1", qa_w[1], 8'h5A);

    // Reset part-way through a re-init restarts the full sweep
    init_req = 1'b1; step();
    init_req = 1'b0;
    repeat (29) step();
    rst_n = 1'b0; step();
    chk("midrst_busy", busy_w[1], 1'b1);
    chk("midrst_q1",   qa_w[1],   8'h00);
    chk("midrst_rv1",  rva_w[1],  1'b0);
    rst_n = 1'b1;
    n = 0;
    while (busy_w[0] && n < 200) begin n++; step(); end
    chk("midrst_len", n, 64);

    // Random traffic over a narrow address window to provoke collisions
    for (int i = 0; i < 300; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
      step();
    end
    idle();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tdp_ram_init
`default_nettype wire

// File: doc/tdp_ram_init.md
TDP_RAM_INIT -- requirements
Module: tdp_ram_init

Interface
REQ-001 SHALL have parameter DATA_W, default 8, word width in bits (1..64).
REQ-002 SHALL have parameter ADDR_W, default 6, address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameters RDW_A and RDW_B, default 0, same-port read-during-write mode: 0 write-first, 1 read-first, 2 no-change.
REQ-004 SHALL have parameter OUT_REG, default 0, extra output register stage when 1.
REQ-005 SHALL have parameter INIT_VAL, default 0, DATA_W-bit value written to every word during initialisation.
REQ-006 SHALL have one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-007 SHALL have init_req, input, 1 bit: restart initialisation when asserted in READY.
REQ-008 SHALL have busy, output, 1 bit: high while initialisation runs.
REQ-009 SHALL have en_a and en_b, input, 1 bit each: port access enable.
REQ-010 SHALL have we_a and we_b, input, 1 bit each: write when en is also high.
REQ-011 SHALL have addr_a and addr_b, input, ADDR_W bits each: word address.
REQ-012 SHALL have data_a and data_b, input, DATA_W bits each: write data.
REQ-013 SHALL have q_a and q_b, output, DATA_W bits each: read data, held between valid results.
REQ-014 SHALL have rvalid_a and rvalid_b, output, 1 bit each: one-cycle pulse marking a new q value.
REQ-015 SHALL have coll, output, 1 bit: pulse flagging a same-address dual write.

Function
REQ-016 SHALL implement a two-state FSM: INIT and READY.
REQ-017 In INIT, one word per cycle SHALL be written with INIT_VAL at counter addresses 0..2**ADDR_W-1; after the last address the FSM SHALL go to READY.
REQ-018 busy SHALL be 1 in INIT and 0 in READY; port accesses in INIT SHALL be ignored, with no write and no rvalid.
REQ-019 init_req=1 in READY SHALL move the FSM to INIT with the counter at 0; init_req in INIT SHALL be ignored.
REQ-020 Read (en=1, we=0) at edge N SHALL give q/rvalid at edge N+1 when OUT_REG=0 and at N+2 when OUT_REG=1.
REQ-021 Write (en=1, we=1) SHALL update the memory at edge N.
REQ-022 On a write, q SHALL follow the port mode: write-first gives the new data with rvalid; read-first gives the old word with rvalid; no-change holds q with rvalid=0.
REQ-023 A write on one port and a read on the other to the same address in the same cycle SHALL return the old word to the reader.
REQ-024 Both ports writing the same address in the same cycle SHALL store data_a; coll SHALL pulse one cycle later, with the same latency as REQ-020.
REQ-025 Each port's own q SHALL still follow REQ-022 during a collision.
REQ-026 Address arithmetic SHALL be modulo 2**ADDR_W, and the init counter SHALL be ADDR_W+1 bits so its terminal count is detectable.

Reset
REQ-027 While rst_n=0 at a clk edge, q_a, q_b, rvalid_a, rvalid_b and coll SHALL be 0, busy SHALL be 1, the FSM SHALL be INIT and the counter 0; memory contents are not reset directly.
REQ-028 Reset asserted mid-INIT or mid-READY SHALL abort any in-flight output pipeline stage and restart initialisation from address 0.

Structure
REQ-029 The RDW mode encodings and FSM state encoding SHALL live in shared package tdp_ram_pkg.
REQ-030 The memory array with its two ports SHALL be sub-module tdp_ram_core, with no reset and inferable as block RAM; tdp_ram_init SHALL own the FSM, the init mux onto port A, the output registers and collision detection.

Verification
REQ-031 Default parameters; release rst_n -> busy=1 for exactly 64 cycles, then 0; reading addresses 0, 31 and 63 on port B -> q_b=8'h00, rvalid_b one cycle after each request.
REQ-032 RDW_A=0, RDW_B=1; write 8'hA5 to addr 5 on both ports in separate cycles over old value 8'h3C -> q_a=8'hA5, then q_b=8'h3C.
REQ-033 A writes 8'h11 and B writes 8'h22 to addr 9 in the same cycle -> coll pulses once; a later read of addr 9 gives 8'h11.
REQ-034 OUT_REG=1; read addr 2 on port A at edge N -> rvalid_a high at edge N+2 only, with q_a holding the value afterwards.
REQ-035 Assert init_req after writing 8'hFF to addr 7, with INIT_VAL=8'h5A -> busy for 64 cycles, port writes during busy are dropped, then a read of addr 7 gives 8'h5A.
REQ-036 Assert rst_n low for one cycle at init count 30 -> outputs 0, and busy then stays high for a full 64 cycles.
